fetch_controller: RTL

Sequencing controller for the instruction-fetch stage. It owns the PC update/select decision, the IF/ID register write-enable and flush, and the request/ready handshake to instruction memory. It arbitrates between sequential fetch, taken-branch redirect and ID-stage hazard stalls. It holds a redirect pending across a multi-cycle memory access so a branch target is never lost. It sits between the hazard/branch logic (ID/EXE) and the PC register, PC mux and instruction memory of IF.

---
 rtl/fetch_controller.sv | 121 ++++++++++++
 1 files changed

// File: rtl/fetch_controller.sv
`default_nettype none
// ============================================================================
// fetch_controller : IF-stage sequencer (PC select/enable, IF/ID control, imem
// handshake). Optional macro FETCH_PERF_CNT_EN adds stall/flush counters.
// Revision: 1.0
// ============================================================================
module fetch_controller #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hazard_stall,
  input  logic              Br_taken,
  input  logic [ADDR_W-1:0] Br_target,
  input  logic              imem_ready,
  output logic              imem_req,
  output logic              pc_write,
  output logic              pc_sel,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic              ifid_write,
  output logic              ifid_flush
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       stall_cycles,
  output logic [31:0]       flush_count
`endif
);

  typedef enum logic [1:0] {
    ST_RESET    = 2'd0,
    ST_FETCH    = 2'd1,
    ST_REDIRECT = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pend_target_q, pend_target_d;

  always_comb begin
    state_d       = state_q;
    pend_target_d = pend_target_q;
    imem_req      = 1'b0;
    pc_write      = 1'b0;
    pc_sel        = 1'b0;
    ifid_write    = 1'b0;
    ifid_flush    = 1'b0;
    redirect_pc   = (state_q == ST_REDIRECT) ? pend_target_q : Br_target;

    case (state_q)
      ST_RESET: begin
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        imem_req = 1'b1;
        // A taken branch outranks a stall; a stall discards any completion.
        if (Br_taken) begin
          ifid_flush = 1'b1;
          if (imem_ready) begin
            pc_write = 1'b1;
            pc_sel   = 1'b1;
          end else begin
            pend_target_d = Br_target;
            state_d       = ST_REDIRECT;
          end
        end else if (!hazard_stall && imem_ready) begin
          pc_write   = 1'b1;
          ifid_write = 1'b1;
        end
      end
      ST_REDIRECT: begin
        // Later branches and stalls are ignored until the held target is loaded.
        imem_req   = 1'b1;
        ifid_flush = 1'b1;
        if (imem_ready) begin
          pc_write = 1'b1;
          pc_sel   = 1'b1;
          state_d  = ST_FETCH;
        end
      end
      default: begin
        state_d = ST_RESET;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_RESET;
      pend_target_q <= '0;
    end else begin
      state_q       <= state_d;
      pend_target_q <= pend_target_d;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cycles_q;
  logic [31:0] flush_count_q;
  logic        stall_inc;

  assign stall_inc = (state_q == ST_FETCH) && hazard_stall && !Br_taken;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      if (stall_inc) begin
        stall_cycles_q <= stall_cycles_q + 32'd1;
      end
      if (ifid_flush) begin
        flush_count_q <= flush_count_q + 32'd1;
      end
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;
`endif

endmodule
`default_nettype wire
